// File: rtl/adder_pkg.sv
// Shared definitions for the conditional-sum adder stages: default width,
// carry-stage FSM encoding and the h_prim inversion mask.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 7;
    localparam int MAX_WIDTH     = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } carry_state_t;

    // Only the arithmetic LSB (index width-1) flips when the carry-in is 1.
    function automatic logic [MAX_WIDTH-1:0] h_prim_mask(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/carry_chain_stage_carry_bit_cell.sv
// One carry-ripple cell: carry out of a single bit position given its carry-in.
module carry_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout
);

    always_comb begin
        cout = (a & b) | ((a ^ b) & cin);
    end

endmodule

// File: rtl/carry_chain_stage.sv
// Carry-precompute stage: ripples the carry-in-0 and carry-in-1 chains and holds
// the four vectors for the sum stage. Define CARRY_CHAIN_FASTPATH_EN for a
// single-cycle combinational build.
module carry_chain_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] half_sum_vector,
    output logic [WIDTH-1:0] h_prim,
    output logic [WIDTH-1:0] carry_generate_vector,
    output logic [WIDTH-1:0] g_prim
);

    localparam logic [WIDTH-1:0] HP_MASK = WIDTH'(h_prim_mask(WIDTH));

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in HOLD.
    carry_state_t     state_q, state_d;
    logic [WIDTH-1:0] hs_q, hs_d;
    logic [WIDTH-1:0] hp_q, hp_d;
    logic [WIDTH-1:0] cg_q, cg_d;
    logic [WIDTH-1:0] gp_q, gp_d;

    assign in_ready              = (state_q == IDLE);
    assign out_valid             = (state_q == HOLD);
    assign half_sum_vector       = hs_q;
    assign h_prim                = hp_q;
    assign carry_generate_vector = cg_q;
    assign g_prim                = gp_q;

`ifdef CARRY_CHAIN_FASTPATH_EN

    // Chain index WIDTH is the incoming carry; each cell feeds the next lower index.
    logic [WIDTH:0] c0_chain;
    logic [WIDTH:0] c1_chain;

    assign c0_chain[WIDTH] = 1'b0;
    assign c1_chain[WIDTH] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fast
        carry_bit_cell u_c0 (
            .a    (a_in[i]),
            .b    (b_in[i]),
            .cin  (c0_chain[i+1]),
            .cout (c0_chain[i])
        );
        carry_bit_cell u_c1 (
            .a    (a_in[i]),
            .b    (b_in[i]),
            .cin  (c1_chain[i+1]),
            .cout (c1_chain[i])
        );
    end

    always_comb begin
        state_d = state_q;
        hs_d    = hs_q;
        hp_d    = hp_q;
        cg_d    = cg_q;
        gp_d    = gp_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hs_d    = a_in ^ b_in;
                    hp_d    = (a_in ^ b_in) ^ HP_MASK;
                    cg_d    = c0_chain[WIDTH-1:0];
                    gp_d    = c1_chain[WIDTH-1:0];
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hs_q    <= '0;
            hp_q    <= '0;
            cg_q    <= '0;
            gp_q    <= '0;
        end else begin
            state_q <= state_d;
            hs_q    <= hs_d;
            hp_q    <= hp_d;
            cg_q    <= cg_d;
            gp_q    <= gp_d;
        end
    end

`else

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LSB = IDX_W'(WIDTH - 1);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_p1;
    logic             at_lsb;
    logic             c0, c1;
    logic             c0_out, c1_out;

    // idx_p1 may wrap when idx is at the LSB, but it is only used when it is not.
    assign idx_p1 = idx_q + IDX_W'(1);
    assign at_lsb = (idx_q == IDX_LSB);
    assign c0     = at_lsb ? 1'b0 : cg_q[idx_p1];
    assign c1     = at_lsb ? 1'b1 : gp_q[idx_p1];

    carry_bit_cell u_c0 (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (c0),
        .cout (c0_out)
    );

    carry_bit_cell u_c1 (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (c1),
        .cout (c1_out)
    );

    always_comb begin
        state_d = state_q;
        hs_d    = hs_q;
        hp_d    = hp_q;
        cg_d    = cg_q;
        gp_d    = gp_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    hs_d    = a_in ^ b_in;
                    hp_d    = (a_in ^ b_in) ^ HP_MASK;
                    cg_d    = '0;
                    gp_d    = '0;
                    idx_d   = IDX_LSB;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                cg_d[idx_q] = c0_out;
                gp_d[idx_q] = c1_out;
                // Exit on writing bit 0 so the counter never wraps.
                if (idx_q == '0) begin
                    state_d = HOLD;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hs_q    <= '0;
            hp_q    <= '0;
            cg_q    <= '0;
            gp_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hs_q    <= hs_d;
            hp_q    <= hp_d;
            cg_q    <= cg_d;
            gp_q    <= gp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
        end
    end

`endif

endmodule
